// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write arbiter: write request struct and x0 constant.
// DATA_WIDTH comes from the project-wide macro; it falls back to 32 when the macro is not defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package rf_arb_pkg;

  localparam int unsigned RF_DATA_W = `DATA_WIDTH;
  localparam int unsigned RF_ADDR_W = 5;

  localparam logic [RF_ADDR_W-1:0] RF_X0 = '0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_req_t;

  function automatic logic is_x0(input logic [RF_ADDR_W-1:0] a);
    return a == RF_X0;
  endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// In-order queue of pending long-latency register writes.
// Every entry's valid bit and address are exported so the owner can compare them against decode sources.
module rf_wr_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              push_i,
  input  rf_wr_req_t                        push_req_i,
  input  logic                              pop_i,
  output rf_wr_req_t                        head_o,
  output logic [CW-1:0]                     count_o,
  output logic [DEPTH-1:0]                  entry_valid_o,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]   entry_addr_o
);

  rf_wr_req_t       mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] valid;
  logic             do_push;
  logic             do_pop;

  // Overflow/underflow requests are dropped here so the pointers can never desynchronise.
  assign do_push = push_i && (count < CW'(DEPTH));
  assign do_pop  = pop_i && (count != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr]   <= push_req_i;
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_comb begin
    entry_addr_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr_o[i] = mem[i].addr;
    end
  end

  assign head_o        = mem[rd_ptr];
  assign count_o       = count;
  assign entry_valid_o = valid;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between writeback (always wins, zero latency) and a
// buffered long-latency unit, with a starvation bubble request and a queued-destination hazard port.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = RF_DATA_W,
  parameter int ADDR_WIDTH   = RF_ADDR_W,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CW = $clog2(LQ_DEPTH) + 1,
  localparam int WW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wb_valid_i,
  input  logic [ADDR_WIDTH-1:0] wb_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  lu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] lu_data_i,
  output logic                  lu_ready_o,
  input  logic [ADDR_WIDTH-1:0] hz_rs1_i,
  input  logic [ADDR_WIDTH-1:0] hz_rs2_i,
  output logic                  hz_hit_o,
  output logic                  stall_req_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_data_o,
  output logic [CW-1:0]         lq_count_o
);

  rf_wr_req_t                        lu_req;
  rf_wr_req_t                        head;
  logic [CW-1:0]                     lq_count;
  logic [LQ_DEPTH-1:0]               entry_valid;
  logic [LQ_DEPTH-1:0][RF_ADDR_W-1:0] entry_addr;
  logic                              lq_empty;
  logic                              wb_busy;
  logic                              push;
  logic                              pop;
  logic [WW-1:0]                     wait_cnt;
  logic                              stall_q;
  logic                              hit_rs1;
  logic                              hit_rs2;

  // LU handshake: a result transfers on a cycle where lu_valid_i && lu_ready_o. lu_ready_o
  // depends only on the registered count (and reset), never on lu_valid_i. x0 results transfer but are dropped.
  assign lu_ready_o = rst_ni && (lq_count < CW'(LQ_DEPTH));
  assign push       = lu_valid_i && lu_ready_o && !is_x0(lu_rd_addr_i);
  assign lu_req     = '{addr: lu_rd_addr_i, data: lu_data_i};

  assign lq_empty = (lq_count == '0);
  assign wb_busy  = wb_valid_i && !is_x0(wb_rd_addr_i);
  assign pop      = rst_ni && !wb_busy && !lq_empty;

  rf_wr_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (push),
    .push_req_i    (lu_req),
    .pop_i         (pop),
    .head_o        (head),
    .count_o       (lq_count),
    .entry_valid_o (entry_valid),
    .entry_addr_o  (entry_addr)
  );

  always_comb begin
    rf_we_o   = 1'b0;
    rf_addr_o = '0;
    rf_data_o = '0;
    if (rst_ni) begin
      if (wb_busy) begin
        rf_we_o   = 1'b1;
        rf_addr_o = wb_rd_addr_i;
        rf_data_o = wb_data_i;
      end else if (!lq_empty) begin
        rf_we_o   = 1'b1;
        rf_addr_o = head.addr;
        rf_data_o = head.data;
      end
    end
  end

  // stall_q lags the saturated counter by one cycle, but drops together with the pop that clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (pop || lq_empty) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WW'(STARVE_LIMIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      stall_q <= (wait_cnt == WW'(STARVE_LIMIT)) && !lq_empty && !pop;
    end
  end

  assign stall_req_o = stall_q;

  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == hz_rs1_i)) hit_rs1 = 1'b1;
      if (entry_valid[i] && (entry_addr[i] == hz_rs2_i)) hit_rs2 = 1'b1;
    end
  end

  assign hz_hit_o   = (!is_x0(hz_rs1_i) && hit_rs1) || (!is_x0(hz_rs2_i) && hit_rs2);
  assign lq_count_o = lq_count;

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between the in-order writeback stage result and a long-latency unit (divider / uncached load path) that completes out of band. Writeback results always win and pass through with zero latency; long-latency results are buffered in a small in-order queue and drained into free writeback slots. A starvation counter requests a pipeline bubble when the queue cannot drain, and a hazard port reports reads of registers whose value is still queued. The block sits between the writeback mux output and the register file write port in the top pipeline module.

## Interface
- `DATA_WIDTH`, `` `DATA_WIDTH ``, register data width
- `ADDR_WIDTH`, 5, register address width
- `LQ_DEPTH`, 2, long-latency queue entries (power of two, ≥2)
- `STARVE_LIMIT`, 4, cycles a non-empty queue may go undrained before a bubble is requested (≥1)

Ports:
- `clk_i` in 1: clock; single clock domain
- `rst_ni` in 1: reset, synchronous, active-low
- `wb_valid_i` in 1: writeback stage writes this cycle
- `wb_rd_addr_i` in ADDR_WIDTH: writeback destination
- `wb_data_i` in DATA_WIDTH: writeback result
- `lu_valid_i` in 1: long-latency result offered
- `lu_rd_addr_i` in ADDR_WIDTH: its destination
- `lu_data_i` in DATA_WIDTH: its data
- `lu_ready_o` out 1: queue can accept
- `hz_rs1_i`, `hz_rs2_i` in ADDR_WIDTH: decode-stage source addresses
- `hz_hit_o` out 1: a source matches a queued destination
- `stall_req_o` out 1: request one writeback bubble
- `rf_we_o` out 1: register file write enable
- `rf_addr_o` out ADDR_WIDTH: write address
- `rf_data_o` out DATA_WIDTH: write data
- `lq_count_o` out $clog2(LQ_DEPTH)+1: entries queued

## Operation
- WB slot is "busy" iff `wb_valid_i` && `wb_rd_addr_i != 0`. WB writes to x0 are suppressed (`rf_we_o`=0 for them).
- Busy slot: `rf_*` = WB request; queue head held.
- Free slot and queue non-empty: `rf_*` = head; head popped at clock edge.
- Free slot and queue empty: `rf_we_o`=0, `rf_addr_o`=0, `rf_data_o`=0.
- Enqueue on `lu_valid_i && lu_ready_o`. `lu_ready_o` = `lq_count_o < LQ_DEPTH`, derived from registered count only (no combinational path from `lu_valid_i`). Entries with rd = 0 are accepted but not stored.
- No bypass: an entry enqueued in cycle N drains no earlier than N+1. Simultaneous push and pop allowed; count unchanged.
- Starvation: `wait_cnt` increments each cycle the queue is non-empty and no pop occurs, saturating at STARVE_LIMIT; clears on any pop or when empty. `stall_req_o` is registered, =1 while `wait_cnt` == STARVE_LIMIT. The pipeline answers with `wb_valid_i`=0 the following cycle; if WB still arrives, WB wins, nothing is dropped, the request holds.
- `hz_hit_o` combinational: (rs1≠0 and matches any valid entry) or (rs2≠0 and matches any valid entry). Upstream stalls decode on a hit; this also prevents WAW between WB and a queued entry, which the arbiter does not resolve.
- Reset (`rst_ni`=0 at edge): queue emptied, `wait_cnt`=0, `stall_req_o`=0. While `rst_ni` is low, `lu_ready_o`=0 and `rf_we_o`=0. Queued entries are discarded on mid-operation reset.

## Timing
- WB → `rf_*`: 0 cycles, combinational.
- LU → `rf_*`: ≥1 cycle; exactly 1 when the next slot is free.
- Full queue: `lu_ready_o`=0 in the cycle after the push that fills it. It returns to 1 the cycle after a pop.
- `stall_req_o` asserts STARVE_LIMIT+1 cycles after the first undrained cycle of a continuously blocked head.
- It deasserts the cycle after the pop.

## Structure
- Shared package `rf_arb_pkg`: `rf_wr_req_t` struct {addr, data}, and the x0 constant.
- Sub-module `rf_wr_fifo`: synchronous FIFO of `rf_wr_req_t`, with push/pop/count and per-entry valid/addr visibility for the hazard compare.
- Arbitration, starvation counter and hazard compare live in the top module.

## Test plan
- WB rd=5 data=0xAA with queue empty → same cycle `rf_we_o`=1, addr 5, data 0xAA; `lq_count_o`=0.
- LU rd=7 data=0x11 at cycle N, WB idle → cycle N+1 `rf_we_o`=1, addr 7, data 0x11; count 1→0.
- Two LU pushes with WB busy every cycle → `lu_ready_o`=0 after the second push; third offer is not accepted; `stall_req_o`=1 five cycles after the first blocked cycle; WB idle → head drains, stall drops next cycle.
- Queue holds rd=3, hz_rs1=3 → `hz_hit_o`=1; with hz_rs1=0 and rd=0 LU push → `hz_hit_o`=0 and count unchanged.
- WB rd=0 valid with queue head rd=9 → head drains that cycle (x0 slot counts as free).
- Reset asserted with 2 entries queued and `stall_req_o`=1 → next cycle count 0, `stall_req_o`=0, `rf_we_o`=0; after release `lu_ready_o`=1.
